// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: one state per clock, Moore outputs except PCen (uses zero).
// Latency: lw 5, sw/R-type/addi 4, beq 3, illegal 2 cycles; no backpressure, the datapath always keeps up.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCen,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       PCsrc,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] dec_state;
    logic       funct_ok;
    logic       decode_illegal;
    logic       pc_write;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT);
    end

    always_comb begin
        state_next     = S_FETCH;
        decode_illegal = 1'b0;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (op == OP_RTYPE && funct_ok) begin
                    state_next = S_EXECUTE;
                end else if (op == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (op == OP_ADDI) begin
                    state_next = S_ADDIEXEC;
                end else begin
                    state_next     = S_FETCH;
                    decode_illegal = 1'b1;
                end
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            // Completing states and the unused codes 11-15 all return to FETCH
            default:    state_next = S_FETCH;
        endcase
    end

    // While in reset the datapath sees a FETCH decode with every write enable held low
    assign dec_state = reset ? state : S_FETCH;

    always_comb begin
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        PCsrc         = 1'b0;
        case (dec_state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                ALUSrcB      = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                case (funct)
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCsrc      = 1'b1;
                branch     = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign PCen      = reset & (pc_write | (branch & zero));
    assign IRWrite   = reset & ir_write_raw;
    assign MemWrite  = reset & mem_write_raw;
    assign RegWrite  = reset & reg_write_raw;
    assign illegal_o = reset & decode_illegal;
    assign state_o   = dec_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by state against hand-derived values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCsrc, illegal_o;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .PCen      (PCen),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUControl(ALUControl),
        .PCsrc     (PCsrc),
        .state_o   (state_o),
        .illegal_o (illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, state_o}, {28'd0, exp});
    endtask

    logic [5:0] fn_tab  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_tab [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
    logic [5:0] ill_op  [2] = '{6'b111111, 6'b000000};
    logic [5:0] ill_fn  [2] = '{6'b000000, 6'b000011};

    initial begin
        reset = 1'b0;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("rst_state", 4'd0);
            check("rst_irwrite", IRWrite, 1'b0);
            check("rst_pcen", PCen, 1'b0);
            check("rst_wr", {MemWrite, RegWrite}, 2'b00);
            check("rst_alusrcb", ALUSrcB, 2'b01);
            check("rst_aluctl", ALUControl, 3'b010);
        end
        reset = 1'b1;
        #1;
        check_state("fetch0_state", 4'd0);
        check("fetch0_irwrite", IRWrite, 1'b1);
        check("fetch0_pcen", PCen, 1'b1);
        check("fetch0_alusrcb", ALUSrcB, 2'b01);
        check("fetch0_iord", IorD, 1'b0);

        // add
        op = 6'b000000; funct = 6'b100000;
        tick(); check_state("add_dec", 4'd1);
        check("add_dec_alusrcb", ALUSrcB, 2'b11);
        check("add_dec_pcen", PCen, 1'b0);
        tick(); check_state("add_exe", 4'd6);
        check("add_exe_aluctl", ALUControl, 3'b010);
        check("add_exe_srca", ALUSrcA, 1'b1);
        check("add_exe_srcb", ALUSrcB, 2'b00);
        tick(); check_state("add_wb", 4'd7);
        check("add_wb_regwrite", RegWrite, 1'b1);
        check("add_wb_regdst", RegDst, 1'b1);
        check("add_wb_memtoreg", MemtoReg, 1'b0);
        tick(); check_state("add_fetch", 4'd0);

        // sub / and / or / slt
        for (int i = 0; i < 4; i++) begin
            funct = fn_tab[i];
            tick(); check_state("rt_dec", 4'd1);
            tick(); check_state("rt_exe", 4'd6);
            check("rt_exe_aluctl", ALUControl, alu_tab[i]);
            tick(); check_state("rt_wb", 4'd7);
            tick(); check_state("rt_fetch", 4'd0);
        end

        // lw
        op = 6'b100011; funct = 6'd0;
        tick(); check_state("lw_dec", 4'd1);
        tick(); check_state("lw_adr", 4'd2);
        check("lw_adr_srcb", ALUSrcB, 2'b10);
        check("lw_adr_srca", ALUSrcA, 1'b1);
        tick(); check_state("lw_rd", 4'd3);
        check("lw_rd_iord", IorD, 1'b1);
        check("lw_rd_memwrite", MemWrite, 1'b0);
        tick(); check_state("lw_wb", 4'd4);
        check("lw_wb_memtoreg", MemtoReg, 1'b1);
        check("lw_wb_regwrite", RegWrite, 1'b1);
        check("lw_wb_regdst", RegDst, 1'b0);
        tick(); check_state("lw_fetch", 4'd0);

        // sw
        op = 6'b101011;
        tick(); check_state("sw_dec", 4'd1);
        tick(); check_state("sw_adr", 4'd2);
        tick(); check_state("sw_wr", 4'd5);
        check("sw_wr_memwrite", MemWrite, 1'b1);
        check("sw_wr_iord", IorD, 1'b1);
        check("sw_wr_regwrite", RegWrite, 1'b0);
        tick(); check_state("sw_fetch", 4'd0);
        check("sw_fetch_memwrite", MemWrite, 1'b0);

        // beq, taken then not taken; zero in DECODE must not move the PC
        op = 6'b000100;
        for (int z = 0; z < 2; z++) begin
            tick(); check_state("beq_dec", 4'd1);
            zero = 1'b1; #1;
            check("beq_dec_zero_pcen", PCen, 1'b0);
            tick(); check_state("beq_br", 4'd8);
            zero = (z == 0); #1;
            check("beq_br_pcen", PCen, (z == 0) ? 1'b1 : 1'b0);
            check("beq_br_pcsrc", PCsrc, 1'b1);
            check("beq_br_aluctl", ALUControl, 3'b110);
            check("beq_br_srcb", ALUSrcB, 2'b00);
            zero = 1'b0;
            tick(); check_state("beq_fetch", 4'd0);
        end

        // illegal opcode and illegal R-type funct
        for (int i = 0; i < 2; i++) begin
            op = ill_op[i]; funct = ill_fn[i];
            tick(); check_state("ill_dec", 4'd1);
            check("ill_pulse", illegal_o, 1'b1);
            check("ill_wr", {RegWrite, MemWrite}, 2'b00);
            tick(); check_state("ill_fetch", 4'd0);
            check("ill_pulse_end", illegal_o, 1'b0);
        end

        // legal DECODE must not flag illegal
        op = 6'b001000; funct = 6'd0;
        tick(); check_state("addi_dec", 4'd1);
        check("addi_dec_illegal", illegal_o, 1'b0);
        tick(); check_state("addi_exe", 4'd9);
        check("addi_exe_srcb", ALUSrcB, 2'b10);
        check("addi_exe_srca", ALUSrcA, 1'b1);
        check("addi_exe_regwrite", RegWrite, 1'b0);
        tick(); check_state("addi_wb", 4'd10);
        check("addi_wb_ctl", {RegDst, MemtoReg, RegWrite}, 3'b001);
        tick(); check_state("addi_fetch", 4'd0);

        // reset during MEMWRITE
        op = 6'b101011;
        tick(); tick(); tick();
        check_state("mid_wr", 4'd5);
        check("mid_wr_memwrite", MemWrite, 1'b1);
        reset = 1'b0; #1;
        check("mid_rst_memwrite", MemWrite, 1'b0);
        check("mid_rst_iord", IorD, 1'b0);
        tick();
        reset = 1'b1; #1;
        check_state("mid_after", 4'd0);
        check("mid_after_irwrite", IRWrite, 1'b1);
        tick(); check_state("mid_dec", 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core. It takes `op` and `funct` from the instruction register and `zero` from the ALU. It generates every select and write enable the datapath consumes, sequencing FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK one step per clock. Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq, addi.

## Interface
- No parameters. Widths are fixed by the MIPS encoding and the datapath control inputs.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `op` in 6: `Instr[31:26]`.
- `funct` in 6: `Instr[5:0]`.
- `zero` in 1: combinational `ALUResult == 0` for the current cycle.
- `PCen` out 1: PC register enable, equal to `PCWrite | (Branch & zero)`.
- `IorD` out 1: memory address select; 0 = PC, 1 = `ALU_o`.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegDst` out 1: register-file write address; 0 = rt, 1 = rd.
- `MemtoReg` out 1: register-file write data; 0 = `ALU_o`, 1 = memory data register.
- `RegWrite` out 1: register-file write enable.
- `ALUSrcA` out 1: 0 = PC, 1 = A register.
- `ALUSrcB` out 2: 00 = B register, 01 = constant 4, 10 = SignExt, 11 = SignExt<<2.
- `ALUControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCsrc` out 1: PC next value; 0 = `ALUResult`, 1 = `ALU_o`.
- `state_o` out 4: current state encoding, for debug.
- `illegal_o` out 1: one-cycle pulse in DECODE when the opcode or funct is unsupported.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10. Codes 11–15 are unreachable and recover to FETCH on the next edge.
- Outputs are decoded from the current state only (Moore). The exception is `PCen`, which also uses `zero`. Any output not listed for a state is 0; `ALUControl` defaults to 010.
- **FETCH**: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, add, PCsrc=0, PCWrite=1. Next state: DECODE.
- **DECODE**: ALUSrcA=0, ALUSrcB=11, add (precomputes the branch target into `ALU_o`). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR.
  - 000000 (R-type) with supported funct: EXECUTE.
  - 000100 (beq): BRANCH.
  - 001000 (addi): ADDIEXEC.
  - Anything else: FETCH, with `illegal_o`=1 for this cycle.
- **MEMADR**: ALUSrcA=1, ALUSrcB=10, add. Next state: MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD**: IorD=1. Next state: MEMWB.
- **MEMWB**: RegDst=0, MemtoReg=1, RegWrite=1. Next state: FETCH.
- **MEMWRITE**: IorD=1, MemWrite=1. Next state: FETCH.
- **EXECUTE**: ALUSrcA=1, ALUSrcB=00. `ALUControl` from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Next state: ALUWB.
- **ALUWB**: RegDst=1, MemtoReg=0, RegWrite=1. Next state: FETCH.
- **BRANCH**: ALUSrcA=1, ALUSrcB=00, sub, PCsrc=1, Branch=1, so `PCen = zero`. Next state: FETCH.
- **ADDIEXEC**: ALUSrcA=1, ALUSrcB=10, add. Next state: ADDIWB.
- **ADDIWB**: RegDst=0, MemtoReg=0, RegWrite=1. Next state: FETCH.
- `op` and `funct` are stable from DECODE until the next FETCH, because IRWrite is asserted only in FETCH. The FSM holds no copy of them.

## Timing
- Reset: with `reset`=0 at a rising edge, the state becomes FETCH.
- While `reset`=0, these outputs are forced to 0 combinationally: PCen, IRWrite, MemWrite, RegWrite, and `illegal_o`. No architectural write can occur during reset.
- Other outputs during reset follow FETCH decode: `state_o`=0, ALUSrcB=01, ALUControl=010, everything else 0.
- The first FETCH executes in the first cycle with `reset`=1.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq: 3.
  - Illegal instruction: 2.
- `zero` must be valid within the BRANCH cycle, since `PCen` is combinational from it. A `zero` glitch in any other state has no effect.
- Reset asserted mid-instruction (e.g. in MEMWRITE): write enables drop in the same cycle, and the state is FETCH at the next edge.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles, then release.
  - During reset: `state_o`=0, all write enables 0.
  - First cycle after release: IRWrite=1, PCen=1, ALUSrcB=01.
- **add** (op=000000, funct=100000): states 0→1→6→7→0.
  - EXECUTE: ALUControl=010, ALUSrcA=1, ALUSrcB=00.
  - ALUWB: RegWrite=1, RegDst=1.
- **sub, and, or, slt**: EXECUTE ALUControl = 110, 000, 001, 111 respectively.
- **lw** (op=100011): states 0→1→2→3→4→0.
  - MEMREAD: IorD=1, MemWrite=0.
  - MEMWB: MemtoReg=1, RegWrite=1, RegDst=0.
- **sw** (op=101011): states 0→1→2→5→0.
  - MEMWRITE: MemWrite=1 for exactly one cycle, IorD=1.
- **beq** (op=000100), checked in BRANCH:
  - `zero`=1: PCen=1, PCsrc=1, ALUControl=110.
  - `zero`=0: PCen=0.
  - Next state FETCH in both cases.
- **Illegal instruction**:
  - op=111111: DECODE→FETCH with `illegal_o`=1 for one cycle and no RegWrite or MemWrite.
  - Same behaviour for op=000000 with funct=000011.
- **addi** (op=001000): states 0→1→9→10→0, with RegDst=0, MemtoReg=0, RegWrite=1 in ADDIWB.
- **Mid-instruction reset**: `reset`=0 during MEMWRITE.
  - MemWrite=0 in the same cycle.
  - `state_o`=0 after the edge.
